// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared definitions for the main-memory arbiter slice.
//  - state_e : access sequencer states (IDLE -> ADDR -> XFER -> ACK)
//  - RQ_*    : requester ids (0 = CPU control unit, 1 = loader/debug port)
package ram_arbiter_pkg;

  localparam int RA_AW  = 8;  // default address width (256-entry memory)
  localparam int RA_DW  = 8;  // default data width
  localparam int NUM_RQ = 2;  // number of requesters

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_XFER = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic RQ_CPU = 1'b0;
  localparam logic RQ_LDR = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester port of the memory arbiter.
//  req   : level request, held until ack
//  we    : 1 = write, 0 = read
//  addr  : access address
//  wdata : write data
//  ack   : one-cycle completion pulse from the arbiter
//  rdata : read data, valid with ack and held until the next read completes
// master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//  req_i     in  2  request bits (bit n = requester n)
//  last_i    in  1  id of the most recently granted requester
//  gnt_o     out 1  granted requester id
//  gnt_vld_o out 1  a grant is being made (any request present)
// With both requesting, the one that was not granted last wins; a lone
// requester always wins. The last-grant register lives in the caller.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       gnt_vld_o
);

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_o     = RQ_CPU;
    if (&req_i)              gnt_o = ~last_i;
    else if (req_i[RQ_LDR])  gnt_o = RQ_LDR;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and access sequencer for the
// 256x8 main memory. Each granted request becomes a 4-cycle sequence:
//   ADDR : mem_sa_o=1 with the latched address
//   XFER : mem_s_o=1 (write, mem_d_in_o=wdata) or mem_e_o=1 (read, capture)
//   ACK  : one-cycle ack to the granted requester
//   IDLE : arbitrate again
// Ports:
//  clk, reset      clock, synchronous active-high reset
//  r0, r1          requester ports (slave side), r0 = CPU, r1 = loader
//  mem_a_o         address to memory (held from ADDR through XFER)
//  mem_sa_o        memory address-register set strobe
//  mem_s_o         memory write strobe
//  mem_e_o         memory read enable strobe
//  mem_d_in_o      write data to memory
//  mem_d_out_i     read data from memory
//  busy_o          1 whenever the sequencer is not idle
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = RA_AW,
  parameter int DW = RA_DW
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  r0,
  ram_arbiter_if.slave  r1,
  output logic [AW-1:0] mem_a_o,
  output logic          mem_sa_o,
  output logic          mem_s_o,
  output logic          mem_e_o,
  output logic [DW-1:0] mem_d_in_o,
  input  logic [DW-1:0] mem_d_out_i,
  output logic          busy_o
);

  // requester ports gathered into id-indexed vectors
  logic [NUM_RQ-1:0]         req_w;
  logic [NUM_RQ-1:0]         we_w;
  logic [NUM_RQ-1:0][AW-1:0] addr_w;
  logic [NUM_RQ-1:0][DW-1:0] wdata_w;

  assign req_w   = {r1.req,   r0.req};
  assign we_w    = {r1.we,    r0.we};
  assign addr_w  = {r1.addr,  r0.addr};
  assign wdata_w = {r1.wdata, r0.wdata};

  // sequencer state and latched request
  state_e                    state_q;
  logic                      gnt_q;
  logic                      we_q;
  logic [DW-1:0]             wdata_q;
  logic                      last_q;

  // registered outputs
  logic [AW-1:0]             mem_a_q;
  logic                      mem_sa_q, mem_s_q, mem_e_q;
  logic [DW-1:0]             mem_d_in_q;
  logic [NUM_RQ-1:0]         ack_q;
  logic [NUM_RQ-1:0][DW-1:0] rdata_q;
  logic                      busy_q;

  logic gnt_w, gnt_vld_w;

  rr_arb2 u_rr (
    .req_i     (req_w),
    .last_i    (last_q),
    .gnt_o     (gnt_w),
    .gnt_vld_o (gnt_vld_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= RQ_CPU;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      last_q     <= RQ_LDR;   // r0 wins the first tie
      mem_a_q    <= '0;
      mem_sa_q   <= 1'b0;
      mem_s_q    <= 1'b0;
      mem_e_q    <= 1'b0;
      mem_d_in_q <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      // strobes and acks are single-cycle pulses
      mem_sa_q <= 1'b0;
      mem_s_q  <= 1'b0;
      mem_e_q  <= 1'b0;
      ack_q    <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_vld_w) begin
            // request fields are frozen here; later changes are ignored
            gnt_q    <= gnt_w;
            we_q     <= we_w[gnt_w];
            wdata_q  <= wdata_w[gnt_w];
            last_q   <= gnt_w;
            mem_a_q  <= addr_w[gnt_w];
            mem_sa_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // sa drops here: the memory lets sa override s, so they never overlap
          if (we_q) begin
            mem_s_q    <= 1'b1;
            mem_d_in_q <= wdata_q;
          end else begin
            mem_e_q    <= 1'b1;
          end
          state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (!we_q) rdata_q[gnt_q] <= mem_d_out_i;
          ack_q[gnt_q] <= 1'b1;
          state_q      <= ST_ACK;
        end
        ST_ACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_a_o    = mem_a_q;
  assign mem_sa_o   = mem_sa_q;
  assign mem_s_o    = mem_s_q;
  assign mem_e_o    = mem_e_q;
  assign mem_d_in_o = mem_d_in_q;
  assign busy_o     = busy_q;

  assign r0.ack   = ack_q[RQ_CPU];
  assign r0.rdata = rdata_q[RQ_CPU];
  assign r1.ack   = ack_q[RQ_LDR];
  assign r1.rdata = rdata_q[RQ_LDR];

endmodule
